// File: rtl/regfile_sync_clr_pkg.sv
// regfile_sync_clr_pkg: shared widths and clear-sequencer state encoding
package regfile_sync_clr_pkg;
  localparam int REGBUS = 32;
  localparam int REGADDRBUS = 5;
  localparam int REGNUM = 32;
  typedef enum logic [1:0] {RF_CLEAR = 2'b01, RF_READY = 2'b10} rf_state_e;
endpackage

// File: rtl/regfile_sync_clr_if.sv
// regfile_sync_clr_if: decode read ports, writeback write port, debug port and stall status
interface regfile_sync_clr_if
  import regfile_sync_clr_pkg::*;
#(
  parameter int DATA_W = REGBUS,
  parameter int ADDR_W = REGADDRBUS
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              busy;
  logic              wr_drop;
  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2, dbg_addr,
    input  rdata1, rdata2, dbg_data, busy, wr_drop
  );
  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2, dbg_addr,
    output rdata1, rdata2, dbg_data, busy, wr_drop
  );
endinterface

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: post-reset sequencer that zeroes registers 1..REG_NUM-1, one per cycle
module regfile_clr_seq
  import regfile_sync_clr_pkg::*;
#(
  parameter int ADDR_W = REGADDRBUS,
  parameter int REG_NUM = REGNUM,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(REG_NUM - 1);
  rf_state_e state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR_ON_RESET ? RF_CLEAR : RF_READY;
      ptr_q   <= ADDR_W'(1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end
  // ptr parks on the last register so it never wraps back to r0
  always_comb begin
    state_d = RF_READY;
    ptr_d   = ptr_q;
    if (state_q == RF_CLEAR) begin
      state_d = (ptr_q == LAST) ? RF_READY : RF_CLEAR;
      ptr_d   = (ptr_q == LAST) ? ptr_q : ptr_q + 1'b1;
    end
  end
  assign busy_o     = (state_q == RF_CLEAR) || rst;
  assign clr_we_o   = (state_q == RF_CLEAR) && !rst;
  assign clr_addr_o = ptr_q;
endmodule

// File: rtl/regfile_sync_clr.sv
// regfile_sync_clr: 2R1W register file, r0 hardwired to zero, write-through bypass, cleared after reset
module regfile_sync_clr
  import regfile_sync_clr_pkg::*;
#(
  parameter int DATA_W = REGBUS,
  parameter int ADDR_W = REGADDRBUS,
  parameter int REG_NUM = REGNUM,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic clk,
  input logic rst,
  regfile_sync_clr_if.slave bus
);
  logic [DATA_W-1:0] mem_q [REG_NUM];
  logic [DATA_W-1:0] dbg_q;
  logic              wr_drop_q;
  logic              busy, clr_we, wr_req;
  logic [ADDR_W-1:0] clr_addr;
  regfile_clr_seq #(
    .ADDR_W(ADDR_W),
    .REG_NUM(REG_NUM),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_seq (
    .clk(clk),
    .rst(rst),
    .busy_o(busy),
    .clr_we_o(clr_we),
    .clr_addr_o(clr_addr)
  );
  assign wr_req = bus.we && (bus.waddr != '0);
  // the clear write owns the array while busy; pipeline writes are dropped
  always_ff @(posedge clk) begin
    if (clr_we) mem_q[clr_addr] <= '0;
    else if (wr_req && !busy) mem_q[bus.waddr] <= bus.wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      dbg_q     <= (busy || bus.dbg_addr == '0) ? '0 : mem_q[bus.dbg_addr];
      wr_drop_q <= busy && wr_req;
    end
  end
  assign bus.rdata1 = (busy || !bus.re1 || bus.raddr1 == '0) ? '0 :
                      (bus.we && bus.waddr == bus.raddr1) ? bus.wdata : mem_q[bus.raddr1];
  assign bus.rdata2 = (busy || !bus.re2 || bus.raddr2 == '0) ? '0 :
                      (bus.we && bus.waddr == bus.raddr2) ? bus.wdata : mem_q[bus.raddr2];
  assign bus.dbg_data = dbg_q;
  assign bus.busy     = busy;
  assign bus.wr_drop  = wr_drop_q;
endmodule

// File: tb/tb_regfile_sync_clr.sv
// tb_regfile_sync_clr: directed table, corner sequences and random traffic against a behavioural model
module tb_regfile_sync_clr;
  logic clk = 1'b1;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  regfile_sync_clr_if bus ();
  regfile_sync_clr dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic we; logic [4:0] waddr; logic [31:0] wdata;
    logic re1; logic [4:0] raddr1; logic re2; logic [4:0] raddr2; logic [4:0] dbg_addr;
    logic [31:0] e1; logic [31:0] e2; logic [31:0] ed;
  } vec_t;

  int vectors = 0, miscompares = 0;
  logic [31:0] m [32];
  int clr_left = 0;
  logic [31:0] dbg_exp = '0;
  logic drop_exp = 1'b0;
  logic last_busy;
  logic [31:0] s1, s2;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", n, a, e);
    end
  endtask

  function automatic logic [31:0] rd_exp(input logic re, input logic [4:0] ra, input logic b);
    if (b || !re || ra == 0) return 32'h0;
    if (bus.we && bus.waddr == ra) return bus.wdata;
    return m[ra];
  endfunction

  task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2,
                        input logic [4:0] da);
    bus.we = we; bus.waddr = wa; bus.wdata = wd;
    bus.re1 = r1; bus.raddr1 = a1; bus.re2 = r2; bus.raddr2 = a2; bus.dbg_addr = da;
  endtask

  task automatic cycle();
    logic b;
    logic [31:0] e1, e2;
    b  = rst || clr_left > 0;
    e1 = rd_exp(bus.re1, bus.raddr1, b);
    e2 = rd_exp(bus.re2, bus.raddr2, b);
    @(negedge clk);
    s1 = bus.rdata1; s2 = bus.rdata2; last_busy = bus.busy;
    chk("rdata1", bus.rdata1, e1);
    chk("rdata2", bus.rdata2, e2);
    chk("busy", 32'(bus.busy), 32'(b));
    @(posedge clk);
    if (rst) begin
      foreach (m[i]) m[i] = '0;
      clr_left = 31; dbg_exp = '0; drop_exp = 1'b0;
    end else begin
      drop_exp = b && bus.we && bus.waddr != 0;
      dbg_exp  = (b || bus.dbg_addr == 0) ? 32'h0 : m[bus.dbg_addr];
      if (!b && bus.we && bus.waddr != 0) m[bus.waddr] = bus.wdata;
      if (clr_left > 0) clr_left--;
    end
    #1;
    chk("dbg_data", bus.dbg_data, dbg_exp);
    chk("wr_drop", 32'(bus.wr_drop), 32'(drop_exp));
  endtask

  task automatic count_busy(output int n);
    n = 0;
    do begin cycle(); n++; end while (last_busy && n < 100);
    n--;
  endtask

  vec_t vecs [7];
  int n;

  initial begin
    foreach (m[i]) m[i] = '0;
    vecs[0] = '{1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0, 5'd7, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd9, 32'h12345678, 1'b1, 5'd9, 1'b1, 5'd9, 5'd9, 32'h12345678, 32'h12345678, 32'h0};
    vecs[3] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0, 5'd9, 32'h0, 32'h0, 32'h12345678};
    vecs[4] = '{1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0};
    vecs[5] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd3, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5};
    vecs[6] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd7, 5'd7, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF};

    // reset then clear, reading r5 throughout
    set_in(0, 0, 0, 1, 5'd5, 0, 0, 0);
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    count_busy(n);
    chk("clear_len", 32'(n), 32'd31);
    for (int r = 1; r < 32; r++) begin
      set_in(0, 0, 0, 1, 5'(r), 1, 5'(r), 5'(r));
      cycle();
      chk("cleared", s1, 32'h0);
    end

    for (int i = 0; i < 7; i++) begin
      set_in(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].re1, vecs[i].raddr1,
             vecs[i].re2, vecs[i].raddr2, vecs[i].dbg_addr);
      cycle();
      chk($sformatf("vec%0d_r1", i), s1, vecs[i].e1);
      chk($sformatf("vec%0d_r2", i), s2, vecs[i].e2);
      chk($sformatf("vec%0d_dbg", i), bus.dbg_data, vecs[i].ed);
      chk($sformatf("vec%0d_drop", i), 32'(bus.wr_drop), 32'h0);
    end

    // write while busy in the 10th clear cycle
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1; cycle(); rst = 1'b0;
    repeat (9) cycle();
    set_in(1, 5'd4, 32'h1, 0, 0, 0, 0, 0);
    cycle();
    chk("drop_pulse", 32'(bus.wr_drop), 32'h1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("drop_end", 32'(bus.wr_drop), 32'h0);
    count_busy(n);
    set_in(0, 0, 0, 1, 5'd4, 0, 0, 0);
    cycle();
    chk("r4_after_drop", s1, 32'h0);

    // reset mid-clear restarts the full sequence
    set_in(1, 5'd1, 32'hCAFEF00D, 0, 0, 0, 0, 0);
    cycle();
    set_in(0, 0, 0, 1, 5'd1, 0, 0, 0);
    cycle();
    chk("r1_written", s1, 32'hCAFEF00D);
    rst = 1'b1; cycle(); rst = 1'b0;
    repeat (14) cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    count_busy(n);
    chk("reclear_len", 32'(n), 32'd31);
    cycle();
    chk("r1_recleared", s1, 32'h0);

    // random traffic, occasional reset
    for (int i = 0; i < 600; i++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      set_in(1'($urandom), wa, $urandom, 1'($urandom_range(0, 3) != 0),
             ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 3) != 0),
             ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)));
      rst = ($urandom_range(0, 149) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
